// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// Frames start/data/parity/stop bits around an external majority-vote
// sampler. It drives the sampler's enable and tick counter, evaluates the
// voted bit at the last tick of every bit period, and presents a checked
// LSB-first byte with a one-cycle valid strobe.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX_IN,
  input  logic [5:0]                  Prescale,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        sampled_bit,
  output logic                        data_samp_en,
  output logic [$clog2(PRESCALE)-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]       P_DATA,
  output logic                        data_valid,
  output logic                        par_err,
  output logic                        stp_err
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q,    state_d;
  logic [EW-1:0]         edge_q,     edge_d;
  logic [BW-1:0]         bit_q,      bit_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_typ_q,  par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q,   p_data_d;
  logic                  valid_q,    valid_d;
  logic                  par_err_q,  par_err_d;
  logic                  stp_err_q,  stp_err_d;
  logic                  samp_en_q,  samp_en_d;

  logic bit_end;
  logic par_expected;

  // Last oversampling tick of the current bit, against the latched ratio.
  assign bit_end      = (6'(edge_q) == (prescale_q - 6'd1));
  assign par_expected = (^shift_q) ^ par_typ_q;

  // State and output registers; a reset mid-frame drops everything.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values settled before the clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      prescale_q <= 6'd16;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      samp_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      samp_en_q  <= samp_en_d;
    end
  end

  // Next-state logic: tick counting, bit framing, checks and the strobe.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so
    // no path leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;

    if (state_q == S_IDLE) begin
      edge_d = '0;
    end else begin
      edge_d = bit_end ? '0 : edge_q + EW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          // Frame configuration is frozen for the whole frame from here on.
          state_d    = S_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
          bit_d      = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          // A start bit that votes high was a glitch on the line.
          state_d = sampled_bit ? S_IDLE : S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_err_d = (sampled_bit != par_expected);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          stp_err_d = ~sampled_bit;
          if (!par_err_q && sampled_bit) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    samp_en_d = (state_d != S_IDLE);
  end

  assign data_samp_en = samp_en_q;
  assign edge_cnt     = edge_q;
  assign P_DATA       = p_data_q;
  assign data_valid   = valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sits directly upstream and downstream of the RX majority-vote sampler. It drives that sampler's data_samp_en and edge_cnt, consumes its sampled_bit, and frames start/data/parity/stop bits. It deserializes the data LSB-first and presents a checked byte with a one-cycle valid strobe. It runs on the oversampling clock, which ticks Prescale times per bit.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE, 16, maximum oversampling ratio; sets the edge_cnt width as $clog2(PRESCALE)

Ports:
CLK  input  1  oversampling clock; the single clock of the block
RST  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  6  runtime oversampling ratio; legal values are even, 4..PRESCALE
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even parity, 1 = odd parity
sampled_bit  input  1  majority-voted bit from the sampler
data_samp_en  output  1  enables sampler capture
edge_cnt  output  $clog2(PRESCALE)  oversample tick within the current bit, 0..Prescale-1
P_DATA  output  DATA_WIDTH  last good received word
data_valid  output  1  one-cycle strobe; P_DATA updated
par_err  output  1  parity mismatch in the current/last frame
stp_err  output  1  stop bit sampled low in the current/last frame

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE.
  - edge_cnt, bit counter and shift register = 0.
  - P_DATA = 0; data_valid, par_err, stp_err, data_samp_en = 0.
  - Reset mid-frame abandons the frame with no flags raised.
- All outputs are registered. data_samp_en = 1 in every state except IDLE.
- Bit timing:
  - edge_cnt increments every cycle outside IDLE.
  - At edge_cnt == Prescale-1 ("bit end") it wraps to 0 and the FSM evaluates sampled_bit.
  - The sampler's sample points must lie below Prescale-1, so sampled_bit is stable at bit end.
- Frame configuration: Prescale, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - edge_cnt held at 0.
  - RX_IN == 0 -> START; clear par_err and stp_err; edge_cnt starts at 0 in the first START cycle.
- START, at bit end:
  - sampled_bit == 0 -> DATA.
  - Otherwise (glitch) -> IDLE; no flags, no data_valid.
- DATA:
  - At each bit end, shift sampled_bit into the MSB of the shift register (LSB-first reception).
  - The bit counter runs 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: -> PARITY if PAR_EN, else -> STOP.
- PARITY, at bit end:
  - Expected bit = XOR of the data bits (even) or its inverse (odd).
  - par_err = (sampled_bit != expected).
  - -> STOP.
- STOP, at bit end:
  - stp_err = ~sampled_bit.
  - If neither par_err nor stp_err is set: P_DATA <= shift register and data_valid = 1 for exactly one cycle.
  - Always -> IDLE.
- Error flags hold their value until the next IDLE->START transition. P_DATA is unchanged on errored frames.
- Latency:
  - F = 1 + DATA_WIDTH + PAR_EN + 1.
  - data_valid is high in cycle F*Prescale, counting the first START cycle as cycle 0.
- Back-to-back frames: IDLE is re-entered for one cycle after STOP and accepts a new start immediately. This costs one cycle of slip per frame, which is within tolerance.
- RX_IN falling during DATA/PARITY/STOP has no effect on state; only bit-end sampling matters.

Test Plan:
1. Prescale=16, PAR_EN=0, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_valid one cycle at cycle 160; P_DATA=0xA5; par_err=stp_err=0.
2. Prescale=8, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid at cycle 88; P_DATA=0x3C. Repeat with parity bit 1 -> par_err=1, no data_valid, P_DATA still 0x3C.
3. PAR_EN=1, PAR_TYP=1, 0x01 with parity 0, stop bit driven 0 -> stp_err=1, par_err=0, no data_valid. Flags clear on the next start edge.
4. RX_IN low for 4 ticks then high (Prescale=16, sampled_bit=1 at start bit end) -> return to IDLE at cycle 15; data_samp_en falls; no flags, no data_valid.
5. Two back-to-back frames 0x55 then 0xFF, no idle gap -> two data_valid pulses with P_DATA 0x55 then 0xFF.
6. Assert RST mid-DATA (bit 4) -> all outputs immediately 0, state IDLE. The next full frame 0x81 is received correctly.
